// File: rtl/keccak_pkg.sv
// Shared Keccak constants: FSM encodings, lane width, rate and domain-separation values.
package keccak_pkg;

    localparam int LANE_W         = 64;
    localparam int RATE_SHAKE128  = 21;
    localparam int RATE_SHAKE256  = 17;
    localparam int RATE_SHA3_512  = 9;

    localparam logic [7:0] DS_SHAKE     = 8'h1F;
    localparam logic [7:0] DS_SHA3      = 8'h06;
    localparam logic [7:0] PAD_END_BYTE = 8'h80;

    // Final pad bit sits in the top byte of the last rate lane.
    localparam logic [LANE_W-1:0] PAD_END_LANE = {PAD_END_BYTE, 56'h0};

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_ABSORB     = 4'd1;
    localparam logic [3:0] ST_PERM_REQ   = 4'd2;
    localparam logic [3:0] ST_PERM_WAIT  = 4'd3;
    localparam logic [3:0] ST_PAD_DS     = 4'd4;
    localparam logic [3:0] ST_PAD_END    = 4'd5;
    localparam logic [3:0] ST_FPERM_REQ  = 4'd6;
    localparam logic [3:0] ST_FPERM_WAIT = 4'd7;
    localparam logic [3:0] ST_DONE       = 4'd8;

endpackage

// File: rtl/keccak_absorb_ctrl_load64.sv
// load64: memory-order word (byte0 in the MSBs) to little-endian Keccak lane.
module load64
    import keccak_pkg::*;
#(
    parameter int BW_DATA = LANE_W
) (
    input  logic [BW_DATA-1:0] i_word,
    output logic [BW_DATA-1:0] o_lane
);

    localparam int NB = BW_DATA / 8;

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign o_lane[8*b +: 8] = i_word[BW_DATA-8-8*b +: 8];
    end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Keccak absorb sequencer: lane XOR-writes, per-rate permutations, pad10*1 with DS.
// Optional ABSORB_PERF_CNT_EN adds o_perm_cnt, a saturating permutation counter.
module keccak_absorb_ctrl
    import keccak_pkg::*;
#(
    parameter int         BW_DATA    = 64,
    parameter int         RATE_LANES = 21,
    parameter int         BW_IDX     = 5,
    parameter logic [7:0] DS         = 8'h1F
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_data,
    input  logic               i_last,
    input  logic [3:0]         i_last_bytes,
    output logic               o_xor_en,
    output logic [BW_IDX-1:0]  o_xor_idx,
    output logic [BW_DATA-1:0] o_xor_data,
    output logic               o_perm_start,
    input  logic               i_perm_done,
    output logic               o_busy,
    output logic               o_done
`ifdef ABSORB_PERF_CNT_EN
   ,output logic [15:0]        o_perm_cnt
`endif
);

    localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(RATE_LANES - 1);

    logic [3:0]         state_q, state_d;
    logic [BW_IDX-1:0]  lane_cnt_q, lane_cnt_d;
    logic               pad_pend_q, pad_pend_d;
    logic               xor_en_q, xor_en_d;
    logic [BW_IDX-1:0]  xor_idx_q, xor_idx_d;
    logic [BW_DATA-1:0] xor_data_q, xor_data_d;
    logic               perm_start_q, perm_start_d;

    logic [BW_DATA-1:0] lane;
    logic [BW_DATA-1:0] keep;
    logic [BW_DATA-1:0] ds_ins;
    logic [BW_DATA-1:0] beat_data;
    logic [3:0]         n_eff;
    logic               partial;
    logic               last_lane;

    load64 #(.BW_DATA(BW_DATA)) u_load64 (
        .i_word (i_data),
        .o_lane (lane)
    );

    // Byte mask and DS insertion for the final (possibly short) beat.
    always_comb begin
        n_eff  = 4'd8;
        keep   = '0;
        ds_ins = '0;
        if (i_last && i_last_bytes < 4'd8) n_eff = i_last_bytes;
        partial   = (n_eff != 4'd8);
        last_lane = (lane_cnt_q == LAST_IDX);
        for (int k = 0; k < 8; k++) begin
            keep[8*k +: 8]   = (k < int'(n_eff))  ? 8'hFF : 8'h00;
            ds_ins[8*k +: 8] = (k == int'(n_eff)) ? DS    : 8'h00;
        end
        beat_data = lane & keep;
        if (partial) begin
            beat_data = beat_data | ds_ins;
            if (last_lane) beat_data = beat_data | PAD_END_LANE;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        pad_pend_d   = pad_pend_q;
        xor_en_d     = 1'b0;
        xor_idx_d    = '0;
        xor_data_d   = '0;
        perm_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_ABSORB;
                    lane_cnt_d = '0;
                    pad_pend_d = 1'b0;
                end
            end
            ST_ABSORB: begin
                if (i_valid) begin
                    xor_en_d   = 1'b1;
                    xor_idx_d  = lane_cnt_q;
                    xor_data_d = beat_data;
                    lane_cnt_d = last_lane ? '0 : lane_cnt_q + 1'b1;
                    if (i_last) begin
                        if (partial) begin
                            state_d = last_lane ? ST_FPERM_REQ : ST_PAD_END;
                        end else if (last_lane) begin
                            // Full final beat closed the block; DS goes into a fresh block.
                            state_d    = ST_PERM_REQ;
                            pad_pend_d = 1'b1;
                        end else begin
                            state_d = ST_PAD_DS;
                        end
                    end else if (last_lane) begin
                        state_d = ST_PERM_REQ;
                    end
                end
            end
            ST_PERM_REQ: begin
                perm_start_d = 1'b1;
                state_d      = ST_PERM_WAIT;
            end
            ST_PERM_WAIT: begin
                if (i_perm_done) begin
                    state_d    = pad_pend_q ? ST_PAD_DS : ST_ABSORB;
                    pad_pend_d = 1'b0;
                end
            end
            ST_PAD_DS: begin
                xor_en_d   = 1'b1;
                xor_idx_d  = lane_cnt_q;
                xor_data_d = {{(BW_DATA-8){1'b0}}, DS};
                if (last_lane) begin
                    xor_data_d = xor_data_d | PAD_END_LANE;
                    state_d    = ST_FPERM_REQ;
                end else begin
                    state_d = ST_PAD_END;
                end
            end
            ST_PAD_END: begin
                xor_en_d   = 1'b1;
                xor_idx_d  = LAST_IDX;
                xor_data_d = PAD_END_LANE;
                state_d    = ST_FPERM_REQ;
            end
            ST_FPERM_REQ: begin
                perm_start_d = 1'b1;
                state_d      = ST_FPERM_WAIT;
            end
            ST_FPERM_WAIT: begin
                if (i_perm_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            lane_cnt_q   <= '0;
            pad_pend_q   <= 1'b0;
            xor_en_q     <= 1'b0;
            xor_idx_q    <= '0;
            xor_data_q   <= '0;
            perm_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            pad_pend_q   <= pad_pend_d;
            xor_en_q     <= xor_en_d;
            xor_idx_q    <= xor_idx_d;
            xor_data_q   <= xor_data_d;
            perm_start_q <= perm_start_d;
        end
    end

    assign o_ready      = (state_q == ST_ABSORB);
    assign o_xor_en     = xor_en_q;
    assign o_xor_idx    = xor_idx_q;
    assign o_xor_data   = xor_data_q;
    assign o_perm_start = perm_start_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);

`ifdef ABSORB_PERF_CNT_EN
    logic [15:0] perm_cnt_q, perm_cnt_d;

    always_comb begin
        perm_cnt_d = perm_cnt_q;
        if (state_q == ST_IDLE && i_start) perm_cnt_d = '0;
        else if (perm_start_q && perm_cnt_q != 16'hFFFF) perm_cnt_d = perm_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) perm_cnt_q <= '0;
        else         perm_cnt_q <= perm_cnt_d;
    end

    assign o_perm_cnt = perm_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Directed bench for keccak_absorb_ctrl: single-beat vector table plus multi-beat sequences.
module tb_keccak_absorb_ctrl;
    import keccak_pkg::*;

    localparam logic [63:0] HI = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  n;
        int          nw;
        logic [4:0]  eidx [3];
        logic [63:0] edat [3];
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rstn, i_start21, i_start17, i_valid, i_last;
    logic [63:0] i_data;
    logic [3:0]  i_last_bytes;
    logic        resp_done21 = 1'b0, man_done21 = 1'b0, resp_done17 = 1'b0;
    logic        i_perm_done21, i_perm_done17;
    logic        o_ready21, o_xor_en21, o_perm_start21, o_busy21, o_done21;
    logic [4:0]  o_xor_idx21;
    logic [63:0] o_xor_data21;
    logic        o_ready17, o_xor_en17, o_perm_start17, o_busy17, o_done17;
    logic [4:0]  o_xor_idx17;
    logic [63:0] o_xor_data17;
`ifdef ABSORB_PERF_CNT_EN
    logic [15:0] perm_cnt21, perm_cnt17;
`endif

    always #5 i_clk = ~i_clk;
    assign i_perm_done21 = resp_done21 | man_done21;
    assign i_perm_done17 = resp_done17;

    keccak_absorb_ctrl #(.RATE_LANES(21)) u_dut21 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start21), .i_valid(i_valid),
        .o_ready(o_ready21), .i_data(i_data), .i_last(i_last), .i_last_bytes(i_last_bytes),
        .o_xor_en(o_xor_en21), .o_xor_idx(o_xor_idx21), .o_xor_data(o_xor_data21),
        .o_perm_start(o_perm_start21), .i_perm_done(i_perm_done21),
        .o_busy(o_busy21), .o_done(o_done21)
`ifdef ABSORB_PERF_CNT_EN
       ,.o_perm_cnt(perm_cnt21)
`endif
    );

    keccak_absorb_ctrl #(.RATE_LANES(17)) u_dut17 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start17), .i_valid(i_valid),
        .o_ready(o_ready17), .i_data(i_data), .i_last(i_last), .i_last_bytes(i_last_bytes),
        .o_xor_en(o_xor_en17), .o_xor_idx(o_xor_idx17), .o_xor_data(o_xor_data17),
        .o_perm_start(o_perm_start17), .i_perm_done(i_perm_done17),
        .o_busy(o_busy17), .o_done(o_done17)
`ifdef ABSORB_PERF_CNT_EN
       ,.o_perm_cnt(perm_cnt17)
`endif
    );

    int  nvec = 0, nerr = 0;
    wr_t wq21[$], wq17[$];
    int  pc21 = 0, pc17 = 0, ovl = 0;
    bit  hold21 = 1'b0;

    // Write / permutation log, sampled on the falling edge.
    initial forever begin
        @(negedge i_clk);
        if (o_xor_en21) wq21.push_back({o_xor_idx21, o_xor_data21});
        if (o_xor_en17) wq17.push_back({o_xor_idx17, o_xor_data17});
        if (o_perm_start21) pc21++;
        if (o_perm_start17) pc17++;
        if ((o_xor_en21 && o_perm_start21) || (o_xor_en17 && o_perm_start17)) ovl++;
    end

    // Permutation core models: done pulse three cycles after a request.
    initial forever begin
        @(negedge i_clk);
        if (o_perm_start21 && !hold21) begin
            repeat (3) @(negedge i_clk);
            resp_done21 = 1'b1;
            @(negedge i_clk);
            resp_done21 = 1'b0;
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (o_perm_start17) begin
            repeat (3) @(negedge i_clk);
            resp_done17 = 1'b1;
            @(negedge i_clk);
            resp_done17 = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input int sel, input int k, input logic [4:0] ei, input logic [63:0] ed);
        wr_t w;
        int  sz;
        sz = sel ? wq17.size() : wq21.size();
        if (k >= sz) begin
            nvec++;
            nerr++;
            $display("FAIL wr%0d: missing write, expected idx %0d data %h", k, ei, ed);
        end else begin
            w = sel ? wq17[k] : wq21[k];
            chk($sformatf("wr%0d_idx", k), 64'(w.idx), 64'(ei));
            chk($sformatf("wr%0d_data", k), w.data, ed);
        end
    endtask

    task automatic start(input int sel);
        if (sel != 0) i_start17 = 1'b1; else i_start21 = 1'b1;
        @(negedge i_clk);
        i_start17 = 1'b0;
        i_start21 = 1'b0;
    endtask

    task automatic send_beat(input int sel, input logic [63:0] d, input logic l, input logic [3:0] n);
        int t;
        i_valid = 1'b1; i_data = d; i_last = l; i_last_bytes = n;
        t = 0;
        while (!(sel != 0 ? o_ready17 : o_ready21) && t < 500) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 500) begin
            nvec++;
            nerr++;
            $display("FAIL beat_accept: o_ready 0 after 500 cycles, expected 1");
        end
        @(negedge i_clk);
        i_valid = 1'b0; i_last = 1'b0; i_last_bytes = 4'd0;
    endtask

    task automatic wait_done(input int sel);
        int t;
        t = 0;
        while (!(sel != 0 ? o_done17 : o_done21) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        chk("done_seen", 64'(t < 3000), 64'd1);
        @(negedge i_clk);
        chk("done_pulse", 64'(sel != 0 ? o_done17 : o_done21), 64'd0);
        chk("idle_after", 64'(sel != 0 ? o_busy17 : o_busy21), 64'd0);
    endtask

    function automatic logic [63:0] pat(input int k);
        return {8'(k), 56'h11_2233_4455_6677};
    endfunction

    function automatic logic [63:0] pat_lane(input int k);
        return {56'h77_6655_4433_2211, 8'(k)};
    endfunction

    vec_t tbl[6];

    task automatic set_vec(input int i, input logic [63:0] d, input logic [3:0] n, input int nw,
                           input logic [4:0] i0, input logic [63:0] d0,
                           input logic [4:0] i1, input logic [63:0] d1,
                           input logic [4:0] i2, input logic [63:0] d2);
        tbl[i].data = d; tbl[i].n = n; tbl[i].nw = nw;
        tbl[i].eidx[0] = i0; tbl[i].edat[0] = d0;
        tbl[i].eidx[1] = i1; tbl[i].edat[1] = d1;
        tbl[i].eidx[2] = i2; tbl[i].edat[2] = d2;
    endtask

    initial begin
        int base, pbase, bad, t;
        i_rstn = 1'b0; i_start21 = 1'b0; i_start17 = 1'b0; i_valid = 1'b0;
        i_last = 1'b0; i_data = '0; i_last_bytes = '0;

        set_vec(0, 64'h0, 4'd0, 2, 5'd0, 64'h1F, 5'd20, HI, 5'd0, 64'h0);
        set_vec(1, 64'h0102030405060708, 4'd3, 2, 5'd0, 64'h0000_0000_1F03_0201, 5'd20, HI, 5'd0, 64'h0);
        set_vec(2, 64'h0102030405060708, 4'd7, 2, 5'd0, 64'h1F07_0605_0403_0201, 5'd20, HI, 5'd0, 64'h0);
        set_vec(3, 64'hAABBCCDDEEFF1122, 4'd1, 2, 5'd0, 64'h0000_0000_0000_1FAA, 5'd20, HI, 5'd0, 64'h0);
        set_vec(4, 64'hDEADBEEFCAFEF00D, 4'd8, 3, 5'd0, 64'h0DF0_FECA_EFBE_ADDE, 5'd1, 64'h1F, 5'd20, HI);
        set_vec(5, 64'h0102030405060708, 4'd12, 3, 5'd0, 64'h0807_0605_0403_0201, 5'd1, 64'h1F, 5'd20, HI);

        repeat (3) @(negedge i_clk);
        chk("rst_ctl21", 64'({o_ready21, o_xor_en21, o_xor_idx21, o_perm_start21, o_busy21, o_done21}), 64'd0);
        chk("rst_data21", o_xor_data21, 64'd0);
        chk("rst_ctl17", 64'({o_ready17, o_xor_en17, o_perm_start17, o_busy17, o_done17}), 64'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 6; i++) begin
            base = wq21.size(); pbase = pc21;
            start(0);
            chk("ready_after_start", 64'(o_ready21), 64'd1);
            send_beat(0, tbl[i].data, 1'b1, tbl[i].n);
            wait_done(0);
            chk($sformatf("v%0d_nwrites", i), 64'(wq21.size() - base), 64'(tbl[i].nw));
            for (int k = 0; k < tbl[i].nw; k++) chk_wr(0, base + k, tbl[i].eidx[k], tbl[i].edat[k]);
            chk($sformatf("v%0d_nperm", i), 64'(pc21 - pbase), 64'd1);
        end

        // 21 full beats, last one full: extra block holding only padding.
        base = wq21.size(); pbase = pc21;
        start(0);
        for (int k = 0; k < 21; k++) send_beat(0, pat(k), k == 20, 4'd8);
        wait_done(0);
        chk("full_nwrites", 64'(wq21.size() - base), 64'd23);
        for (int k = 0; k < 21; k++) chk_wr(0, base + k, 5'(k), pat_lane(k));
        chk_wr(0, base + 21, 5'd0, 64'h1F);
        chk_wr(0, base + 22, 5'd20, HI);
        chk("full_nperm", 64'(pc21 - pbase), 64'd2);
`ifdef ABSORB_PERF_CNT_EN
        chk("perf_cnt", 64'(perm_cnt21), 64'd2);
`endif

        // RATE 17, short final beat in the last rate lane.
        base = wq17.size(); pbase = pc17;
        start(1);
        for (int k = 0; k < 16; k++) send_beat(1, pat(k), 1'b0, 4'd0);
        send_beat(1, 64'h0102030405060708, 1'b1, 4'd5);
        wait_done(1);
        chk("r17_nwrites", 64'(wq17.size() - base), 64'd17);
        chk_wr(1, base + 15, 5'd15, pat_lane(15));
        chk_wr(1, base + 16, 5'd16, 64'h8000_1F05_0403_0201);
        chk("r17_nperm", 64'(pc17 - pbase), 64'd1);

        // Permutation backpressure and a stray done pulse while absorbing.
        hold21 = 1'b1;
        base = wq21.size(); pbase = pc21;
        start(0);
        man_done21 = 1'b1;
        @(negedge i_clk);
        man_done21 = 1'b0;
        chk("stray_done_ready", 64'(o_ready21), 64'd1);
        for (int k = 0; k < 21; k++) send_beat(0, pat(k), 1'b0, 4'd0);
        t = 0;
        while (!o_perm_start21 && t < 100) begin @(negedge i_clk); t++; end
        chk("bp_perm_req", 64'(o_perm_start21), 64'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_ready21 || o_xor_en21 || !o_busy21) bad++;
        end
        chk("bp_quiet", 64'(bad), 64'd0);
        man_done21 = 1'b1;
        @(negedge i_clk);
        man_done21 = 1'b0;
        hold21 = 1'b0;
        chk("bp_resume_ready", 64'(o_ready21), 64'd1);
        send_beat(0, 64'h0102030405060708, 1'b1, 4'd2);
        wait_done(0);
        chk("bp_nwrites", 64'(wq21.size() - base), 64'd23);
        chk_wr(0, base + 20, 5'd20, pat_lane(20));
        chk_wr(0, base + 21, 5'd0, 64'h1F_0201);
        chk_wr(0, base + 22, 5'd20, HI);
        chk("bp_nperm", 64'(pc21 - pbase), 64'd2);

        // Reset while waiting for a permutation, then a clean restart.
        hold21 = 1'b1;
        start(0);
        for (int k = 0; k < 21; k++) send_beat(0, pat(k), 1'b0, 4'd0);
        t = 0;
        while (!o_perm_start21 && t < 100) begin @(negedge i_clk); t++; end
        @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        chk("midrst_ctl", 64'({o_ready21, o_xor_en21, o_xor_idx21, o_perm_start21, o_busy21, o_done21}), 64'd0);
        chk("midrst_data", o_xor_data21, 64'd0);
        base = wq21.size(); pbase = pc21;
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
        hold21 = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("postrst_idle", 64'({o_busy21, o_ready21}), 64'd0);
        chk("postrst_nowrites", 64'(wq21.size() - base), 64'd0);
        start(0);
        send_beat(0, 64'h0, 1'b1, 4'd0);
        wait_done(0);
        chk_wr(0, base, 5'd0, 64'h1F);
        chk_wr(0, base + 1, 5'd20, HI);
        chk("postrst_nperm", 64'(pc21 - pbase), 64'd1);

        chk("xor_perm_overlap", 64'(ovl), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
